// File: rtl/trace_buffer_if.sv
// ============================================================================
// trace_buffer_if: pipeline trace input bus and readout handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface trace_buffer_if #(
  parameter int NCH  = 5,
  parameter int XLEN = 32,
  parameter int TS_W = 16
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } tracer_bus_t;

  tracer_bus_t [NCH-1:0] trace_i;
  logic [NCH-1:0]        trace_valid_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [XLEN-1:0]       rd_pc_o;
  logic [31:0]           rd_inst_o;
  logic [TS_W-1:0]       rd_ts_o;

  modport master (
    output trace_i, trace_valid_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_inst_o, rd_ts_o
  );

  modport slave (
    input  trace_i, trace_valid_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_inst_o, rd_ts_o
  );
endinterface

`default_nettype wire

// File: rtl/trace_buffer.sv
// ============================================================================
// trace_buffer: triggered circular capture of one pipeline channel, FIFO readout
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_buffer #(
  parameter int NCH   = 5,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int XLEN  = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  trace_buffer_if.slave            bus,
  input  logic                     arm_i,
  input  logic [$clog2(NCH)-1:0]   ch_sel_i,
  input  logic                     trig_en_i,
  input  logic [XLEN-1:0]          trig_pc_i,
  input  logic [$clog2(DEPTH)-1:0] post_cnt_i,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(NCH);
  localparam int ENT_W = TS_W + XLEN + 32;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic            w_wr;
  logic            w_sel_valid;
  logic [XLEN-1:0] w_pc;
  logic [31:0]     w_inst;
  logic [AW-1:0]   w_rd_ptr;
  logic            w_rd_valid;

  assign w_sel_valid = (32'(sel_q) < NCH) && bus.trace_valid_i[sel_q];
  assign w_pc        = bus.trace_i[sel_q].pc;
  assign w_inst      = bus.trace_i[sel_q].inst;
  // count never exceeds DEPTH, so the low bits give the oldest slot
  assign w_rd_ptr    = wr_ptr_q - count_q[AW-1:0];
  assign w_rd_valid  = (state_q == DONE) && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    w_wr     = 1'b0;
    if (arm_i) begin
      state_d  = ARMED;
      sel_d    = ch_sel_i;
      rem_d    = post_cnt_i;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        ARMED, POST: begin
          if (w_sel_valid) begin
            w_wr     = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == FULL) ovf_d = 1'b1;
            else                 count_d = count_q + (AW+1)'(1);
            if (state_q == ARMED) begin
              if (!trig_en_i || (w_pc == trig_pc_i))
                state_d = (rem_q == '0) ? DONE : POST;
            end else begin
              rem_d = rem_q - AW'(1);
              if (rem_q == AW'(1)) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (w_rd_valid && bus.rd_ready_i) begin
            count_d = count_q - (AW+1)'(1);
            if (count_q == (AW+1)'(1)) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      sel_q    <= '0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + TS_W'(1);
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage is deliberately not reset; stale slots are hidden by count
  always_ff @(posedge ACLK) begin
    if (w_wr) mem_q[wr_ptr_q] <= {ts_q, w_pc, w_inst};
  end

  assign {bus.rd_ts_o, bus.rd_pc_o, bus.rd_inst_o} = w_rd_valid ? mem_q[w_rd_ptr] : '0;
  assign bus.rd_valid_o = w_rd_valid;
  assign state_o        = state_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_trace_buffer.sv
// ============================================================================
// tb_trace_buffer: scoreboard bench for trace_buffer capture, trigger and readout
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trace_buffer;
  localparam int NCH   = 5;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int XLEN  = 32;
  localparam int ENT_W = TS_W + XLEN + 32;

  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic        arm_i  = 1'b0;
  logic [2:0]  ch_sel_i = '0;
  logic        trig_en_i = 1'b0;
  logic [31:0] trig_pc_i = '0;
  logic [3:0]  post_cnt_i = '0;
  logic [1:0]  state_o;
  logic [4:0]  count_o;
  logic        overflow_o;

  logic [TS_W-1:0]  m_ts = '0;
  logic [ENT_W-1:0] sb_q [$];
  int n_checks = 0;
  int n_err    = 0;

  trace_buffer_if #(.NCH(NCH), .XLEN(XLEN), .TS_W(TS_W)) bus ();

  trace_buffer #(.NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W), .XLEN(XLEN)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .bus        (bus),
    .arm_i      (arm_i),
    .ch_sel_i   (ch_sel_i),
    .trig_en_i  (trig_en_i),
    .trig_pc_i  (trig_pc_i),
    .post_cnt_i (post_cnt_i),
    .state_o    (state_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 ACLK = ~ACLK;

  // Reference timestamp: value the DUT should stamp on a write in the current cycle
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) m_ts <= '0;
    else        m_ts <= m_ts + 16'd1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic arm(input int ch, input logic en, input logic [31:0] tpc, input int post);
    arm_i      = 1'b1;
    ch_sel_i   = 3'(ch);
    trig_en_i  = en;
    trig_pc_i  = tpc;
    post_cnt_i = 4'(post);
    tick();
    arm_i      = 1'b0;
    sb_q.delete();
  endtask

  // Selected channel carries pc; the others carry distractor traffic
  task automatic drive(input logic [NCH-1:0] vmask, input int ch, input logic [31:0] pc, input logic cap);
    for (int c = 0; c < NCH; c++) begin
      bus.trace_i[c].pc   = 32'hDEAD_0000 + 32'(c);
      bus.trace_i[c].inst = 32'h0BAD_0000 + 32'(c);
    end
    bus.trace_i[ch].pc   = pc;
    bus.trace_i[ch].inst = pc ^ 32'hA5A5_0000;
    bus.trace_valid_i    = vmask;
    if (cap) begin
      sb_q.push_back({m_ts, pc, pc ^ 32'hA5A5_0000});
      if (sb_q.size() > DEPTH) void'(sb_q.pop_front());
    end
    tick();
    bus.trace_valid_i = '0;
  endtask

  task automatic drain(input int n, input string tag);
    logic [ENT_W-1:0] e;
    int w;
    for (int i = 0; i < n; i++) begin
      bus.rd_ready_i = 1'b1;
      w = 0;
      while (!bus.rd_valid_o && w < 50) begin
        tick();
        w++;
      end
      if (!bus.rd_valid_o) begin
        check($sformatf("%s_timeout%0d", tag, i), 96'(bus.rd_valid_o), 96'd1);
        bus.rd_ready_i = 1'b0;
        return;
      end
      if (sb_q.size() == 0) begin
        check($sformatf("%s_extra%0d", tag, i), 96'd1, 96'd0);
        bus.rd_ready_i = 1'b0;
        return;
      end
      e = sb_q.pop_front();
      check($sformatf("%s_pop%0d", tag, i), {bus.rd_ts_o, bus.rd_pc_o, bus.rd_inst_o}, 96'(e));
      tick();
    end
    bus.rd_ready_i = 1'b0;
  endtask

  initial begin
    logic [ENT_W-1:0] e0;
    int guard;
    bus.trace_valid_i = '0;
    bus.rd_ready_i    = 1'b0;
    for (int c = 0; c < NCH; c++) bus.trace_i[c] = '0;

    // Reset values
    #1;
    check("rst_state", 96'(state_o), 96'd0);
    check("rst_count", 96'(count_o), 96'd0);
    check("rst_ovf",   96'(overflow_o), 96'd0);
    check("rst_rdv",   96'(bus.rd_valid_o), 96'd0);
    check("rst_rdfields", {bus.rd_ts_o, bus.rd_pc_o, bus.rd_inst_o}, 96'd0);
    tick();
    tick();
    ARESET = 1'b0;

    // Basic capture on channel 4, free trigger, 3 post entries
    arm(4, 1'b0, 32'h0, 3);
    check("b_armed", 96'(state_o), 96'd1);
    check("b_count0", 96'(count_o), 96'd0);
    drive(5'b00011, 4, 32'h0000_0040, 1'b0);
    check("b_ignore_other", 96'(state_o), 96'd1);
    for (int i = 0; i < 4; i++) drive(5'b10001, 4, 32'h0000_1000 + 32'(i*4), 1'b1);
    check("b_done", 96'(state_o), 96'd3);
    check("b_count4", 96'(count_o), 96'd4);
    drain(4, "b");
    check("b_idle", 96'(state_o), 96'd0);
    check("b_rdv_idle", 96'(bus.rd_valid_o), 96'd0);

    // PC trigger with wrap-around and overflow, then stalled readout
    arm(1, 1'b1, 32'h100, 3);
    for (int i = 0; i < 20; i++) drive(5'b00010, 1, 32'h0C0 + 32'(i*4), 1'b1);
    check("o_done", 96'(state_o), 96'd3);
    check("o_ovf", 96'(overflow_o), 96'd1);
    check("o_count16", 96'(count_o), 96'd16);
    check("o_first_pc", 96'(bus.rd_pc_o), 96'h0D0);
    e0 = sb_q[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s_hold%0d", i), {bus.rd_ts_o, bus.rd_pc_o, bus.rd_inst_o}, 96'(e0));
      check($sformatf("s_cnt%0d", i), 96'(count_o), 96'd16);
    end
    drain(15, "o");
    check("o_last_pc", 96'(bus.rd_pc_o), 96'h10C);
    drain(1, "o_last");
    check("o_idle", 96'(state_o), 96'd0);

    // Re-arm while in POST discards the capture
    arm(2, 1'b1, 32'h540, 5);
    for (int i = 0; i < 17; i++) drive(5'b00100, 2, 32'h500 + 32'(i*4), 1'b0);
    check("r_post", 96'(state_o), 96'd2);
    check("r_ovf_set", 96'(overflow_o), 96'd1);
    check("r_rdv_post", 96'(bus.rd_valid_o), 96'd0);
    arm(2, 1'b0, 32'h0, 0);
    check("r_armed", 96'(state_o), 96'd1);
    check("r_count0", 96'(count_o), 96'd0);
    check("r_ovf0", 96'(overflow_o), 96'd0);
    drive(5'b00100, 2, 32'h0000_0777, 1'b1);
    check("r_done", 96'(state_o), 96'd3);
    check("r_count1", 96'(count_o), 96'd1);
    drain(1, "r");
    check("r_idle", 96'(state_o), 96'd0);

    // Asynchronous reset during readout
    arm(0, 1'b0, 32'h0, 4);
    for (int i = 0; i < 5; i++) drive(5'b00001, 0, 32'h2000 + 32'(i*4), 1'b1);
    check("x_count5", 96'(count_o), 96'd5);
    bus.rd_ready_i = 1'b1;
    #2;
    ARESET = 1'b1;
    #1;
    check("x_state", 96'(state_o), 96'd0);
    check("x_count", 96'(count_o), 96'd0);
    check("x_rdv", 96'(bus.rd_valid_o), 96'd0);
    check("x_rdpc", 96'(bus.rd_pc_o), 96'd0);
    tick();
    ARESET = 1'b0;
    bus.rd_ready_i = 1'b0;
    sb_q.delete();
    drive(5'b00001, 0, 32'h3000, 1'b0);
    check("x_idle_nowrite", 96'(count_o), 96'd0);

    // Timestamp wrap between two consecutive captured writes
    guard = 0;
    while (m_ts != 16'hFFFE && guard < 70000) begin
      tick();
      guard++;
    end
    check("t_wait", 96'(m_ts), 96'hFFFE);
    arm(0, 1'b0, 32'h0, 1);
    drive(5'b00001, 0, 32'h4000, 1'b0);
    drive(5'b00001, 0, 32'h4004, 1'b0);
    check("t_done", 96'(state_o), 96'd3);
    check("t_ts0", 96'(bus.rd_ts_o), 96'hFFFF);
    check("t_pc0", 96'(bus.rd_pc_o), 96'h4000);
    bus.rd_ready_i = 1'b1;
    tick();
    check("t_ts1", 96'(bus.rd_ts_o), 96'h0000);
    check("t_pc1", 96'(bus.rd_pc_o), 96'h4004);
    tick();
    bus.rd_ready_i = 1'b0;
    check("t_idle", 96'(state_o), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL provide parameter NCH, default 5: number of traced pipeline channels (IF, ID, EX, MEM, WB order).
REQ-002 SHALL provide parameter DEPTH, default 16: entry count, power of two, >= 2.
REQ-003 SHALL provide parameter TS_W, default 16: timestamp width.
REQ-004 SHALL provide parameter XLEN, default 32: from CPU_profile.
REQ-005 SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-006 SHALL have port ACLK, input, 1: the single clock.
REQ-007 SHALL have port ARESET, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port trace_i, input, NCH x tracer_bus_t: per-channel trace bus.
REQ-009 SHALL have port trace_valid_i, input, NCH: channel holds a valid instruction this cycle.
REQ-010 SHALL have port arm_i, input, 1: start or restart a capture.
REQ-011 SHALL have port ch_sel_i, input, $clog2(NCH): captured channel.
REQ-012 SHALL have port trig_en_i, input, 1: enable PC-match trigger.
REQ-013 SHALL have port trig_pc_i, input, XLEN: trigger PC.
REQ-014 SHALL have port post_cnt_i, input, $clog2(DEPTH): post-trigger entries.
REQ-015 SHALL have port state_o, input-side none, output, 2: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1: valid entries held.
REQ-017 SHALL have port overflow_o, output, 1: oldest entry overwritten this capture.
REQ-018 SHALL have port rd_valid_o, output, 1: readout entry available.
REQ-019 SHALL have port rd_ready_i, input, 1: readout consumer accepts.
REQ-020 SHALL have ports rd_pc_o (output, XLEN), rd_inst_o (output, 32) and rd_ts_o (output, TS_W): readout entry fields.

Function
REQ-021 SHALL run a free-running TS_W timestamp counter, incrementing every cycle and wrapping from all-ones to 0.
REQ-022 An entry SHALL be {timestamp, pc, inst} of trace_i[sel] in the cycle of the write.
REQ-023 arm_i=1 in any state SHALL enter ARMED next cycle, latch ch_sel_i to sel and post_cnt_i to rem, and clear wr_ptr, count, overflow; arm_i has priority over all other events; no write occurs in the arm cycle.
REQ-024 ARMED: trace_valid_i[sel]=1 SHALL write at wr_ptr, advance wr_ptr mod DEPTH, and increment count saturating at DEPTH.
REQ-025 A write with count=DEPTH SHALL overwrite the oldest entry and set overflow_o until the next arm.
REQ-026 Trigger SHALL be a write in ARMED with trig_en_i=0, or with trig_en_i=1 and pc equal to trig_pc_i; the trigger entry is itself stored.
REQ-027 On trigger: rem=0 SHALL go to DONE; otherwise SHALL go to POST.
REQ-028 POST: each valid write SHALL store as in ARMED and decrement rem; the write making rem 0 SHALL go to DONE next cycle.
REQ-029 IDLE and DONE SHALL perform no writes.
REQ-030 DONE: rd_valid_o SHALL equal (count!=0), and rd_* SHALL present entry (wr_ptr-count) mod DEPTH, oldest first.
REQ-031 rd_valid_o&&rd_ready_i SHALL pop, decrementing count; rd_* SHALL hold stable while rd_valid_o&&!rd_ready_i.
REQ-032 The pop making count 0 SHALL go to IDLE next cycle.
REQ-033 rd_valid_o SHALL be 0 outside DONE.
REQ-034 Non-selected channels SHALL be ignored.

Reset
REQ-035 ARESET SHALL, asynchronously, set state IDLE, timestamp 0, wr_ptr 0, count_o 0, overflow_o 0, rd_valid_o 0, sel 0, rem 0.
REQ-036 rd_pc_o, rd_inst_o and rd_ts_o SHALL be 0 under reset.
REQ-037 Reset SHALL not clear entry memory; entries are unobservable until rewritten.
REQ-038 Reset mid-capture or mid-readout SHALL abandon it with no further pops or writes.

Verification
REQ-039 DEPTH=16, sel=4, trig_en=0, post_cnt=3, 4 valid cycles -> DONE, count_o=4; 4 pops return PCs in order; IDLE after the last pop.
REQ-040 trig_en=1, trig_pc=0x100, 20 valid PCs 0x0C0..0x10C step 4 (0x100 is 17th), post_cnt=3 -> overflow_o=1, count_o=16, first read pc=0x0D0, last 0x10C.
REQ-041 Hold rd_ready_i=0 for 3 cycles in DONE -> rd_* unchanged and count_o unchanged; a later pop returns the next entry.
REQ-042 arm_i during POST -> ARMED next cycle, count_o=0, overflow_o=0; prior entries never read out.
REQ-043 Timestamp at 0xFFFF, then valid on consecutive cycles -> rd_ts_o values 0xFFFF then 0x0000.
REQ-044 ARESET during readout with count_o=5 -> immediately IDLE, count_o=0, rd_valid_o=0.
